// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversamples RX_IN, majority-votes three mid-bit samples,
// reassembles LSB-first frames and pulses Data_valid / Parity_error /
// Stop_error for one cycle, one cycle after the stop bit's last edge.
// Optional macro UART_RX_SYNC_EN adds a 2-flop input synchronizer (+2 cycles).
module uart_rx_deserializer #(
    parameter int Data_width     = 8,
    parameter int Prescale_width = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [Prescale_width-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [Data_width-1:0]     P_DATA,
    output logic                      Data_valid,
    output logic                      Parity_error,
    output logic                      Stop_error
);
    localparam int PW = Prescale_width;
    localparam int BW = $clog2(Data_width + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic rx;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    // Two-stage synchronizer, idles high so reset never looks like a start bit
    always_ff @(posedge CLK) begin
        if (RST) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], RX_IN};
    end
    assign rx = sync_q[1];
`else
    assign rx = RX_IN;
`endif

    state_t                state_q, state_d;
    logic [PW-1:0]         cnt_q, cnt_d, ps_q, ps_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  pe_q, pe_d, pt_q, pt_d;
    logic                  s0_q, s0_d, s1_q, s1_d, bit_q, bit_d;
    logic [Data_width-1:0] shift_q, shift_d, p_data_q, p_data_d;
    logic                  pfail_q, pfail_d;
    logic                  pend_vld_q, pend_vld_d, pend_perr_q, pend_perr_d;
    logic                  pend_serr_q, pend_serr_d;
    logic                  vld_q, vld_d, perr_q, perr_d, serr_q, serr_d;
    logic                  last, start_now;
    logic [PW-1:0]         half, ps_legal;

    assign half = ps_q >> 1;
    assign last = (cnt_q == ps_q - 1'b1);

    // Unsupported oversampling ratios fall back to 8
    always_comb begin
        ps_legal = PW'(8);
        if (Prescale == PW'(16) || Prescale == PW'(32)) ps_legal = Prescale;
    end

    // Next-state logic: bit timing, majority sampling, frame FSM, output staging
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bcnt_d      = bcnt_q;
        ps_d        = ps_q;
        pe_d        = pe_q;
        pt_d        = pt_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        pfail_d     = pfail_q;
        pend_vld_d  = 1'b0;
        pend_perr_d = 1'b0;
        pend_serr_d = 1'b0;
        vld_d       = pend_vld_q;
        perr_d      = pend_perr_q;
        serr_d      = pend_serr_q;
        p_data_d    = pend_vld_q ? shift_q : p_data_q;
        start_now   = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
            if (cnt_q == half - 1'b1) s0_d = rx;
            if (cnt_q == half)        s1_d = rx;
            if (cnt_q == half + 1'b1) bit_d = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
        end

        case (state_q)
            IDLE: if (!rx) start_now = 1'b1;
            START: if (last) begin
                bcnt_d  = '0;
                state_d = bit_q ? IDLE : DATA;
            end
            DATA: if (last) begin
                shift_d = {bit_q, shift_q[Data_width-1:1]};
                bcnt_d  = bcnt_q + 1'b1;
                if (bcnt_q == BW'(Data_width - 1)) state_d = pe_q ? PARITY : STOP;
            end
            PARITY: if (last) begin
                pfail_d = bit_q ^ (^shift_q) ^ pt_q;
                state_d = STOP;
            end
            STOP: if (last) begin
                pend_vld_d  = bit_q & ~pfail_q;
                pend_serr_d = ~bit_q;
                pend_perr_d = pfail_q;
                state_d     = IDLE;
                // IDLE's start detection folded into this edge so a start bit
                // directly after the stop bit costs no gap cycle
                if (!rx) start_now = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (start_now) begin
            state_d = START;
            cnt_d   = '0;
            ps_d    = ps_legal;
            pe_d    = PAR_EN;
            pt_d    = PAR_TYP;
            pfail_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bcnt_q      <= '0;
            ps_q        <= PW'(8);
            pe_q        <= 1'b0;
            pt_q        <= 1'b0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            bit_q       <= 1'b1;
            shift_q     <= '0;
            pfail_q     <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_perr_q <= 1'b0;
            pend_serr_q <= 1'b0;
            vld_q       <= 1'b0;
            perr_q      <= 1'b0;
            serr_q      <= 1'b0;
            p_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcnt_q      <= bcnt_d;
            ps_q        <= ps_d;
            pe_q        <= pe_d;
            pt_q        <= pt_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            pfail_q     <= pfail_d;
            pend_vld_q  <= pend_vld_d;
            pend_perr_q <= pend_perr_d;
            pend_serr_q <= pend_serr_d;
            vld_q       <= vld_d;
            perr_q      <= perr_d;
            serr_q      <= serr_d;
            p_data_q    <= p_data_d;
        end
    end

    assign P_DATA       = p_data_q;
    assign Data_valid   = vld_q;
    assign Parity_error = perr_q;
    assign Stop_error   = serr_q;
endmodule
